// File: rtl/utopia_rx_phy_model.sv
// PHY-side model of NUM_CH Utopia L1 Rx ports: host loads cells into per-channel FIFOs,
// ATM layer pulls words with Rx_en_n; data/soc/clav are registered (1 clock after enable), full drops writes.
module utopia_rx_phy_model #(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 8,
  parameter int CELL_WORDS  = 53,
  parameter int DEPTH_CELLS = 4,
  localparam int CHW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [CHW-1:0]           wr_ch,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [NUM_CH-1:0]        wr_full,
  output logic [15:0]              ovf_cnt,
  input  logic [NUM_CH-1:0]        Rx_en_n,
  output logic [NUM_CH*DATA_W-1:0] Rx_data,
  output logic [NUM_CH-1:0]        Rx_soc,
  output logic [NUM_CH-1:0]        Rx_clav
);

  localparam int TOT = DEPTH_CELLS * CELL_WORDS;
  localparam int PW  = (TOT > 1) ? $clog2(TOT) : 1;
  localparam int IW  = (CELL_WORDS > 1) ? $clog2(CELL_WORDS) : 1;
  localparam int CW  = $clog2(DEPTH_CELLS + 1);
  localparam int UW  = $clog2(TOT + 1);

  localparam logic [PW-1:0] PTR_LAST = PW'(TOT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(CELL_WORDS - 1);
  localparam logic [UW-1:0] USED_MAX = UW'(TOT);

  logic        ch_ok;
  logic        drop;
  logic [15:0] ovf_q;

  // Out-of-range channels are treated like a full FIFO: dropped and counted.
  assign ch_ok   = (int'(wr_ch) < NUM_CH);
  assign drop    = wr_en && (!ch_ok || wr_full[wr_ch]);
  assign ovf_cnt = ovf_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_q <= '0;
    end else if (drop && (ovf_q != 16'hFFFF)) begin
      ovf_q <= ovf_q + 16'd1;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_W-1:0] mem [TOT];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [IW-1:0]     wr_idx;
    logic [IW-1:0]     rd_idx;
    logic [IW-1:0]     rd_idx_nx;
    logic [CW-1:0]     cell_cnt;
    logic [CW-1:0]     cell_cnt_nx;
    logic [UW-1:0]     used;
    logic [UW-1:0]     used_nx;
    logic [DATA_W-1:0] data_q;
    logic              soc_q;
    logic              clav_q;
    logic              full_q;
    logic              wr_hit;
    logic              rd_hit;
    logic              commit;
    logic              rd_last;

    assign wr_hit  = wr_en && ch_ok && (wr_ch == CHW'(c)) && !full_q;
    assign rd_hit  = !Rx_en_n[c] && clav_q;
    assign commit  = wr_hit && (wr_idx == IDX_LAST);
    assign rd_last = rd_hit && (rd_idx == IDX_LAST);

    // used counts every stored word, partial cell included, so full covers both sides.
    always_comb begin
      rd_idx_nx = rd_idx;
      if (rd_hit) begin
        rd_idx_nx = rd_last ? '0 : rd_idx + 1'b1;
      end
      cell_cnt_nx = cell_cnt;
      if (commit && !rd_last) begin
        cell_cnt_nx = cell_cnt + 1'b1;
      end else if (rd_last && !commit) begin
        cell_cnt_nx = cell_cnt - 1'b1;
      end
      used_nx = used;
      if (wr_hit && !rd_hit) begin
        used_nx = used + 1'b1;
      end else if (rd_hit && !wr_hit) begin
        used_nx = used - 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        wr_idx   <= '0;
        rd_idx   <= '0;
        cell_cnt <= '0;
        used     <= '0;
        data_q   <= '0;
        soc_q    <= 1'b0;
        clav_q   <= 1'b0;
        full_q   <= 1'b0;
      end else begin
        if (wr_hit) begin
          wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
          wr_idx <= (wr_idx == IDX_LAST) ? '0 : wr_idx + 1'b1;
        end
        if (rd_hit) begin
          data_q <= mem[rd_ptr];
          rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
        end
        soc_q    <= rd_hit && (rd_idx == '0);
        rd_idx   <= rd_idx_nx;
        cell_cnt <= cell_cnt_nx;
        used     <= used_nx;
        clav_q   <= (cell_cnt_nx != '0) || (rd_idx_nx != '0);
        full_q   <= (used_nx == USED_MAX);
      end
    end

    always_ff @(posedge clk) begin
      if (wr_hit) begin
        mem[wr_ptr] <= wr_data;
      end
    end

    assign Rx_data[c*DATA_W +: DATA_W] = data_q;
    assign Rx_soc[c]                   = soc_q;
    assign Rx_clav[c]                  = clav_q;
    assign wr_full[c]                  = full_q;
  end

endmodule

// File: tb/tb_utopia_rx_phy_model.sv
// Bench for utopia_rx_phy_model: scenario table, directed pause/16-bit sequences, randomized traffic vs queue model.
module tb_utopia_rx_phy_model;

  localparam int NCH = 4;
  localparam int CWD = 53;
  localparam int TOT = 212;

  localparam int OP_RST = 0;
  localparam int OP_WR  = 1;
  localparam int OP_RD  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [7:0]  wr_data;
  logic [3:0]  en_n;
  logic [3:0]  wr_full;
  logic [15:0] ovf;
  logic [31:0] rx_data;
  logic [3:0]  soc;
  logic [3:0]  clav;

  utopia_rx_phy_model dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .wr_full(wr_full), .ovf_cnt(ovf), .Rx_en_n(en_n), .Rx_data(rx_data),
    .Rx_soc(soc), .Rx_clav(clav)
  );

  logic        b_rst;
  logic        b_wr_en;
  logic [0:0]  b_wr_ch;
  logic [15:0] b_wr_data;
  logic [1:0]  b_en_n;
  logic [1:0]  b_full;
  logic [15:0] b_ovf;
  logic [31:0] b_data;
  logic [1:0]  b_soc;
  logic [1:0]  b_clav;

  utopia_rx_phy_model #(.NUM_CH(2), .DATA_W(16), .CELL_WORDS(27), .DEPTH_CELLS(4)) dut16 (
    .clk(clk), .rst(b_rst), .wr_en(b_wr_en), .wr_ch(b_wr_ch), .wr_data(b_wr_data),
    .wr_full(b_full), .ovf_cnt(b_ovf), .Rx_en_n(b_en_n), .Rx_data(b_data),
    .Rx_soc(b_soc), .Rx_clav(b_clav)
  );

  // Reference model: committed words awaiting read, words of the cell being written, read position.
  logic [7:0]  cq [NCH][$];
  logic [7:0]  pq [NCH][$];
  int          pos [NCH];
  logic [31:0] e_data;
  logic [3:0]  e_soc;
  logic [3:0]  e_clav;
  logic [3:0]  e_full;
  logic [15:0] e_ovf;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int         op;
    int         ch;
    int         n;
    int         base;
    logic [3:0] x_clav;
    logic [3:0] x_full;
    int         x_ovf;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [3:0] old_full;
    logic [3:0] old_clav;
    int         c;
    if (!rst) begin
      for (int k = 0; k < NCH; k++) begin
        cq[k].delete();
        pq[k].delete();
        pos[k] = 0;
      end
      e_data = '0; e_soc = '0; e_clav = '0; e_full = '0; e_ovf = '0;
      return;
    end
    old_full = e_full;
    old_clav = e_clav;
    for (int k = 0; k < NCH; k++) begin
      e_soc[k] = 1'b0;
      if (!en_n[k] && old_clav[k] && cq[k].size() > 0) begin
        e_data[k*8 +: 8] = cq[k].pop_front();
        e_soc[k] = (pos[k] == 0);
        pos[k] = (pos[k] + 1) % CWD;
      end
    end
    if (wr_en) begin
      c = int'(wr_ch);
      if (c >= NCH || old_full[c]) begin
        if (e_ovf != 16'hFFFF) e_ovf = e_ovf + 16'd1;
      end else begin
        pq[c].push_back(wr_data);
        if (pq[c].size() == CWD) begin
          while (pq[c].size() > 0) cq[c].push_back(pq[c].pop_front());
        end
      end
    end
    for (int k = 0; k < NCH; k++) begin
      e_full[k] = ((cq[k].size() + pq[k].size()) == TOT);
      e_clav[k] = (cq[k].size() != 0);
    end
  endtask

  task automatic compare_all();
    chk("rx_data", rx_data, e_data);
    chk("rx_soc", {28'b0, soc}, {28'b0, e_soc});
    chk("rx_clav", {28'b0, clav}, {28'b0, e_clav});
    chk("wr_full", {28'b0, wr_full}, {28'b0, e_full});
    chk("ovf_cnt", {16'b0, ovf}, {16'b0, e_ovf});
  endtask

  task automatic step(input logic we, input logic [1:0] ch, input logic [7:0] d,
                      input logic [3:0] en, input logic rs);
    wr_en = we; wr_ch = ch; wr_data = d; en_n = en; rst = rs;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic rd1(input int ch);
    step(1'b0, 2'd0, 8'd0, ~(4'b0001 << ch), 1'b1);
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] en_r;
    int         guard;
    rst = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_data = '0; en_n = 4'hF;
    b_rst = 1'b0; b_wr_en = 1'b0; b_wr_ch = '0; b_wr_data = '0; b_en_n = 2'b11;
    e_data = '0; e_soc = '0; e_clav = '0; e_full = '0; e_ovf = '0;
    for (int k = 0; k < NCH; k++) pos[k] = 0;

    tbl[0]  = '{OP_RST, 0, 1,   0,    4'h0, 4'h0, 0};
    tbl[1]  = '{OP_WR,  0, 53,  0,    4'h1, 4'h0, 0};
    tbl[2]  = '{OP_RD,  0, 53,  0,    4'h0, 4'h0, 0};
    tbl[3]  = '{OP_WR,  2, 212, 'h20, 4'h4, 4'h4, 0};
    tbl[4]  = '{OP_WR,  2, 3,   'hEE, 4'h4, 4'h4, 3};
    tbl[5]  = '{OP_RD,  2, 53,  0,    4'h4, 4'h0, 3};
    tbl[6]  = '{OP_WR,  3, 20,  'h50, 4'h4, 4'h0, 3};
    tbl[7]  = '{OP_WR,  3, 33,  'h64, 4'hC, 4'h0, 3};
    tbl[8]  = '{OP_RST, 0, 1,   0,    4'h0, 4'h0, 0};
    tbl[9]  = '{OP_WR,  3, 20,  'h70, 4'h0, 4'h0, 0};
    tbl[10] = '{OP_RST, 0, 1,   0,    4'h0, 4'h0, 0};
    tbl[11] = '{OP_WR,  3, 53,  'h80, 4'h8, 4'h0, 0};
    tbl[12] = '{OP_RD,  3, 53,  0,    4'h0, 4'h0, 0};

    for (int k = 0; k < 13; k++) begin
      case (tbl[k].op)
        OP_RST: step(1'b0, 2'd0, 8'd0, 4'hF, 1'b0);
        OP_WR: for (int i = 0; i < tbl[k].n; i++)
                 step(1'b1, 2'(tbl[k].ch), 8'(tbl[k].base + i), 4'hF, 1'b1);
        default: for (int i = 0; i < tbl[k].n; i++) rd1(tbl[k].ch);
      endcase
      chk($sformatf("tbl%0d_clav", k), {28'b0, clav}, {28'b0, tbl[k].x_clav});
      chk($sformatf("tbl%0d_full", k), {28'b0, wr_full}, {28'b0, tbl[k].x_full});
      chk($sformatf("tbl%0d_ovf", k), {16'b0, ovf}, 32'(tbl[k].x_ovf));
    end

    // Pause mid-cell on ch1 after word 10, then resume.
    for (int i = 0; i < 53; i++) step(1'b1, 2'd1, 8'(8'h40 + i), 4'hF, 1'b1);
    rd1(1);
    chk("pause_first_data", {24'b0, rx_data[15:8]}, 32'h40);
    chk("pause_first_soc", {31'b0, soc[1]}, 32'd1);
    for (int i = 0; i < 10; i++) rd1(1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 2'd0, 8'd0, 4'hF, 1'b1);
      chk("pause_hold_data", {24'b0, rx_data[15:8]}, 32'h4A);
      chk("pause_hold_soc", {31'b0, soc[1]}, 32'd0);
      chk("pause_hold_clav", {31'b0, clav[1]}, 32'd1);
    end
    rd1(1);
    chk("pause_resume_data", {24'b0, rx_data[15:8]}, 32'h4B);
    for (int i = 0; i < 41; i++) rd1(1);
    chk("pause_last_data", {24'b0, rx_data[15:8]}, 32'h74);
    chk("pause_clav_low", {31'b0, clav[1]}, 32'd0);

    // All channels loaded with distinct patterns, drained with staggered random enables.
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < 53; i++) step(1'b1, 2'(c), 8'((c << 6) | i), 4'hF, 1'b1);
    guard = 0;
    while (clav != 4'h0 && guard < 2000) begin
      en_r = 4'($urandom);
      step(1'b0, 2'd0, 8'd0, en_r, 1'b1);
      guard++;
    end
    chk("conc_drained", {28'b0, clav}, 32'd0);

    // Random traffic: write-heavy phase (reaches full/overflow), then read-heavy phase.
    for (int ph = 0; ph < 2; ph++) begin
      for (int n = 0; n < 2000; n++) begin
        for (int c = 0; c < NCH; c++)
          en_r[c] = (ph == 0) ? (($urandom % 8) != 0) : (($urandom % 8) == 0);
        step(($urandom % 4) != 0, 2'($urandom), 8'($urandom), en_r, ($urandom % 700) != 0);
      end
    end

    // 16-bit, 27-word build.
    rst = 1'b1; wr_en = 1'b0; en_n = 4'hF;
    b_rst = 1'b0;
    @(posedge clk); #1;
    b_rst = 1'b1;
    chk("b16_rst_data", b_data, 32'd0);
    chk("b16_rst_flags", {24'b0, b_clav, b_soc, b_full}, 32'd0);
    chk("b16_rst_ovf", {16'b0, b_ovf}, 32'd0);
    for (int i = 0; i < 27; i++) begin
      b_wr_en = 1'b1; b_wr_ch = 1'b0; b_wr_data = 16'(i);
      @(posedge clk); #1;
      if (i == 25) chk("b16_clav_partial", {30'b0, b_clav}, 32'd0);
    end
    b_wr_en = 1'b0;
    chk("b16_clav_commit", {30'b0, b_clav}, 32'd1);
    b_en_n = 2'b10;
    for (int i = 0; i < 27; i++) begin
      @(posedge clk); #1;
      chk($sformatf("b16_data%0d", i), {16'b0, b_data[15:0]}, 32'(i));
      chk($sformatf("b16_soc%0d", i), {31'b0, b_soc[0]}, 32'(i == 0));
    end
    b_en_n = 2'b11;
    chk("b16_clav_end", {30'b0, b_clav}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
